// File: rtl/scan_pkg.sv
// Shared constants and state type for the LED matrix row scanner.
// The BLANK state is only entered when SCAN_BLANK_EN is defined.
package scan_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FRAME_W = ROWS * COLS;
  localparam int ROW_W   = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
    row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << row;
  endfunction

endpackage

// File: rtl/matrix_scan_row_timer.sv
// Phase timer for the row scanner: counts cycles of the current dwell or
// blank phase and strobes o_tc on the last cycle of that phase.
module row_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [CW-1:0] i_limit,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  // Terminal count is the last cycle of a phase of length i_limit.
  assign o_tc = i_en && (r_cnt == (i_limit - CW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// 8x8 LED matrix row scanner with a double-buffered frame input.
// Optional inter-row blanking is compiled in with the SCAN_BLANK_EN macro.
module matrix_scan
  import scan_pkg::state_t, scan_pkg::IDLE, scan_pkg::SCAN,
         scan_pkg::ROWS, scan_pkg::COLS, scan_pkg::FRAME_W,
         scan_pkg::ROW_W, scan_pkg::row_onehot;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_in,
  // frame_in is taken on any rising edge where frame_valid and frame_ready
  // are both high; frame_valid alone has no effect and nothing is dropped.
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [ROWS-1:0]    row_sel,
  output logic [COLS-1:0]    col_data,
  output logic               frame_done
);

  state_t             r_state;
  state_t             w_next_state;
  logic [ROW_W-1:0]   r_row;
  logic [FRAME_W-1:0] r_active;
  logic [FRAME_W-1:0] r_pending;
  logic               r_pending_full;

  logic               w_accept;
  logic               w_row_adv;
  logic               w_frame_end;
  logic               w_last_row;
  logic               w_tmr_en;
  logic               w_tmr_clr;
  logic               w_tmr_tc;
  logic [7:0]         w_tmr_limit;

  row_timer #(.CW(8)) u_row_timer (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_tmr_en),
    .i_clr   (w_tmr_clr),
    .i_limit (w_tmr_limit),
    .o_tc    (w_tmr_tc)
  );

  assign frame_ready = (r_state == IDLE) ? 1'b1 : ~r_pending_full;
  assign w_accept    = frame_valid && frame_ready;
  assign w_last_row  = (r_row == ROW_W'(ROWS - 1));

`ifdef SCAN_BLANK_EN
  // With blanking, a row ends on the last blank cycle that follows it.
  assign w_row_adv = (r_state == scan_pkg::BLANK) && w_tmr_tc;
`else
  assign w_row_adv = (r_state == SCAN) && w_tmr_tc;
  logic w_unused_blank;
  assign w_unused_blank = (BLANK == 0);
`endif

  assign w_frame_end = w_row_adv && w_last_row;
  assign frame_done  = w_frame_end;

  always_comb begin
    w_next_state = r_state;
    row_sel      = '0;
    col_data     = '0;
    w_tmr_en     = 1'b0;
    w_tmr_clr    = 1'b1;
    w_tmr_limit  = 8'(DWELL);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        row_sel   = row_onehot(r_row);
        col_data  = r_active[{r_row, 3'b000} +: COLS];
        w_tmr_en  = 1'b1;
        w_tmr_clr = 1'b0;
`ifdef SCAN_BLANK_EN
        if (w_tmr_tc) begin
          w_next_state = scan_pkg::BLANK;
        end
`endif
      end
`ifdef SCAN_BLANK_EN
      scan_pkg::BLANK: begin
        w_tmr_en    = 1'b1;
        w_tmr_clr   = 1'b0;
        w_tmr_limit = 8'(BLANK);
        if (w_tmr_tc) begin
          w_next_state = SCAN;
        end
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Swap at the frame boundary only happens with pending full, and an accept
  // outside IDLE only happens with pending empty, so the two never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row          <= '0;
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_active <= frame_in;
        r_row    <= '0;
      end
    end else begin
      if (w_row_adv) begin
        r_row <= r_row + ROW_W'(1);
      end
      if (w_frame_end && r_pending_full) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (w_accept) begin
        r_pending      <= frame_in;
        r_pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed + randomized bench for matrix_scan against a time-based frame model.
module tb_matrix_scan;

  localparam int DWELL_P = 4;
  localparam int BLANK_P = 1;
`ifdef SCAN_BLANK_EN
  localparam int B_CYC = BLANK_P;
`else
  localparam int B_CYC = 0;
`endif
  localparam int RP = DWELL_P + B_CYC;
  localparam int P  = 8 * RP;

  localparam logic [63:0] F1 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] F2 = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] F3 = 64'h8142_2418_1824_4281;

  logic        clk;
  logic        reset;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;

  matrix_scan #(.DWELL(DWELL_P), .BLANK(BLANK_P)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int g_cyc   = 0;
  int first_done = -1;
  int seen_done  = 0;

  // Reference model: position within the frame in cycles, plus the buffers.
  logic        m_run;
  int          m_t;
  logic [63:0] m_act;
  logic [63:0] m_pend;
  logic        m_pf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_act = '0; m_pend = '0; m_pf = 1'b0;
  endtask

  function automatic logic model_ready();
    return !m_run || !m_pf;
  endfunction

  task automatic model_edge(input logic acc, input logic [63:0] d);
    if (!m_run) begin
      if (acc) begin
        m_run = 1'b1; m_t = 0; m_act = d;
      end
    end else begin
      if (m_t == P - 1) begin
        m_t = 0;
        if (m_pf) begin
          m_act = m_pend; m_pf = 1'b0;
        end
      end else begin
        m_t++;
      end
      if (acc) begin
        m_pend = d; m_pf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int          row;
    int          off;
    logic [7:0]  e_sel;
    logic [7:0]  e_col;
    logic        e_done;
    e_sel = '0; e_col = '0; e_done = 1'b0;
    if (m_run) begin
      row = m_t / RP;
      off = m_t % RP;
      if (off < DWELL_P) begin
        e_sel = 8'(1 << row);
        e_col = m_act[row*8 +: 8];
      end
      e_done = (m_t == P - 1);
    end
    check("row_sel", row_sel, e_sel);
    check("col_data", col_data, e_col);
    check("frame_done", frame_done, e_done);
    check("frame_ready", frame_ready, model_ready());
    check("onehot", ($countones(row_sel) <= 1), 1);
  endtask

  // One clock cycle: drive at negedge, check, clock, advance model.
  task automatic step(input logic v, input logic [63:0] d, output logic acc);
    frame_valid = v;
    frame_in    = d;
    #1;
    check_outputs();
    if (frame_done === 1'b1) begin
      seen_done++;
      if (first_done < 0) first_done = g_cyc;
    end
    acc = v && model_ready();
    @(posedge clk);
    model_edge(acc, d);
    @(negedge clk);
    g_cyc++;
  endtask

  initial begin
    logic acc;
    int   a1;
    int   c;
    int   f3_cyc;
    int   found;

    reset = 1'b1; frame_valid = 1'b0; frame_in = '0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_row_sel", row_sel, 8'h00);
    check("rst_col_data", col_data, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_ready", frame_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // No frame offered: stays dark, never signals a frame end.
    seen_done = 0;
    for (int i = 0; i < 100; i++) step(1'b0, {$urandom, $urandom}, acc);
    check("idle_no_done", seen_done, 0);

    first_done = -1;
    a1 = g_cyc;
    step(1'b1, F1, acc);
    check("f1_accept", acc, 1'b1);
    check("f1_first_row", {row_sel, col_data}, 16'h0128);
    for (int i = 0; i < 9; i++) step(1'b0, '0, acc);

    step(1'b1, F2, acc);
    check("f2_accept", acc, 1'b1);
    check("ready_low_pending", frame_ready, 1'b0);

    // Third frame held valid; it can only land after the boundary swap.
    f3_cyc = -1;
    for (int k = 0; k < 2 * P; k++) begin
      c = g_cyc;
      step(1'b1, F3, acc);
      if (acc) begin
        f3_cyc = c;
        break;
      end
    end
    frame_valid = 1'b0;
    check("f3_accept_cycle", f3_cyc, a1 + P + 1);
    check("f1_done_latency", first_done - a1, P);

    for (int i = 0; i < 3 * P; i++) step(1'b0, '0, acc);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) == 0), {$urandom, $urandom}, acc);

    // Park in the middle of row 3, then reset between clock edges.
    found = 0;
    for (int k = 0; k < 3 * P; k++) begin
      if (m_run && (m_t / RP == 3) && (m_t % RP == 1)) begin
        found = 1;
        break;
      end
      step(1'b0, '0, acc);
    end
    check("reached_row3", found, 1);
    check("row3_active", row_sel, 8'h08);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_row_sel", row_sel, 8'h00);
    check("midrst_col_data", col_data, 8'h00);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_frame_ready", frame_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b0, '0, acc);
    step(1'b1, F2, acc);
    check("restart_accept", acc, 1'b1);
    check("restart_row0", {row_sel, col_data}, 16'h0100);
    for (int i = 0; i < P + 5; i++) step(1'b0, '0, acc);

    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 1) == 0), {$urandom, $urandom}, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter: DWELL, 4, clock cycles each row is driven (legal 1..255).
REQ-002 Parameter: BLANK, 1, blanking cycles after each row when SCAN_BLANK_EN is defined (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_in  input  64  8x8 grid from the fsm shift_seed; row r = frame_in[8r+7:8r], column c = bit 8r+c.
REQ-006 frame_valid  input  1  frame_in holds a new generation.
REQ-007 frame_ready  output  1  block can accept a frame this cycle.
REQ-008 row_sel  output  8  one-hot row enable, bit r drives row r; all-zero when dark.
REQ-009 col_data  output  8  column pattern for the selected row; zero when row_sel is zero.
REQ-010 frame_done  output  1  one-cycle pulse marking the end of a full 8-row scan.

Function
REQ-011 Block SHALL hold two 64-bit buffers: active (being scanned) and pending (next frame), plus a pending_full flag.
REQ-012 frame_ready SHALL equal NOT pending_full, except in IDLE where it SHALL be 1.
REQ-013 A frame SHALL be accepted only on a cycle with frame_valid and frame_ready both high; frame_valid without frame_ready SHALL be ignored, and no frame SHALL be dropped once accepted.
REQ-014 FSM states SHALL be IDLE, SCAN, BLANK.
REQ-015 IDLE: row_sel=0, col_data=0; on accept, frame_in loads active directly, row=0, dwell count=0, next state SCAN, so row_sel=8'h01 on the cycle after accept.
REQ-016 SCAN: row_sel=1<<row, col_data=active[8row+7:8row]; after DWELL cycles go to BLANK if SCAN_BLANK_EN is defined, else advance row in SCAN.
REQ-017 BLANK: row_sel=0, col_data=0 for BLANK cycles, then advance row in SCAN.
REQ-018 Row advance SHALL wrap 7->0; at the wrap (frame boundary), if pending_full then active<=pending and pending_full<=0, else active is re-scanned unchanged.
REQ-019 frame_done SHALL be high exactly on the final cycle of the row 7 period: the last BLANK cycle when SCAN_BLANK_EN is defined, otherwise the last DWELL cycle.
REQ-020 Accept in SCAN/BLANK SHALL write pending and set pending_full; an accept coinciding with a frame boundary on which pending was empty SHALL land in pending and be displayed from the following boundary.
REQ-021 Frame period SHALL be 8*DWELL cycles, or 8*(DWELL+BLANK) with SCAN_BLANK_EN.
REQ-022 row_sel SHALL never have more than one bit set.

Reset
REQ-023 Reset asserted (any cycle, including mid-scan) SHALL immediately force row_sel=0, col_data=0, frame_done=0, frame_ready=1, clear both buffers and pending_full, zero counters, state IDLE.
REQ-024 After reset deasserts, the block SHALL stay in IDLE until the first accepted frame.

Configuration
REQ-025 Macro SCAN_BLANK_EN: when defined, BLANK state and BLANK parameter are compiled in (ghosting suppression between rows); when undefined, BLANK state is absent, BLANK is unused and rows are back-to-back.

Structure
REQ-026 Package scan_pkg SHALL hold ROWS=8, COLS=8, FRAME_W=64 and the state enum type (IDLE, SCAN, BLANK).
REQ-027 One sub-module row_timer SHALL count dwell/blank cycles and emit a terminal-count strobe; the FSM, buffers and handshake live in matrix_scan.

Verification
REQ-028 Reset, then frame 64'h0412_6424_0034_3C28 with valid, DWELL=4, no macro -> row_sel 01..80 each held 4 cycles, col_data 28,3C,34,00,24,64,12,04; frame_done pulse on cycle 32 after accept.
REQ-029 Same frame with SCAN_BLANK_EN, BLANK=1 -> one dark cycle between rows, frame period 40, frame_done on the blank cycle after row 7.
REQ-030 Second frame 64'hFFFF_0000_FFFF_0000 offered mid-scan -> accepted, frame_ready low until the boundary, new pattern starts at row 0 of next frame, first frame completes unaltered.
REQ-031 Third frame offered while pending full -> frame_ready=0, not accepted until the boundary, then accepted on first ready cycle.
REQ-032 Reset asserted during row 3 -> outputs zero in the same cycle, IDLE, frame_ready=1; next frame restarts scan at row 0.
REQ-033 No frame after reset for 100 cycles -> row_sel=0, col_data=0, frame_done never pulses.
